// File: rtl/dsp_subsystem_pkg.sv
// Shared constants and types for the I/Q power-measurement subsystem:
// register map, reset values, datapath widths and the AHB data-phase record.
package dsp_subsystem_pkg;

   localparam int ACC_W = 48;   // power accumulator width
   localparam int CNT_W = 17;   // block sample counter width (N up to 65536)
   localparam int IDX_W = 6;    // word index taken from haddr[7:2]

   // Register word indices (byte offset = index * 4)
   typedef enum logic [IDX_W-1:0] {
      REG_CTRL       = 6'h00,
      REG_BLK_LEN    = 6'h01,
      REG_THRESH     = 6'h02,
      REG_IRQ_EN     = 6'h03,
      REG_IRQ_STAT   = 6'h04,
      REG_RES_POW_LO = 6'h05,
      REG_RES_POW_HI = 6'h06,
      REG_RES_PEAK   = 6'h07,
      REG_CNT        = 6'h08,
      REG_LAST_IQ    = 6'h09,
      REG_ID         = 6'h0A
   } reg_idx_e;

   localparam logic        CTRL_EN_RST = 1'b0;
   localparam logic [15:0] BLK_LEN_RST = 16'h03FF;
   localparam logic [31:0] THRESH_RST  = 32'hFFFF_FFFF;
   localparam logic [1:0]  IRQ_EN_RST  = 2'b00;
   localparam logic [31:0] ID_VALUE    = 32'h4453_5031;

   localparam int IRQ_DONE = 0;
   localparam int IRQ_OVER = 1;

   // Latched result of the most recently completed block
   typedef struct packed {
      logic [ACC_W-1:0] pow;
      logic [31:0]      peak;
   } blk_result_t;

   // Captured AHB address phase, acted upon during the following data phase
   typedef struct packed {
      logic             valid;
      logic             write;
      logic [IDX_W-1:0] idx;
   } ahb_dp_t;

endpackage

// File: rtl/dsp_power_acc.sv
// Per-sample I^2+Q^2 power, block accumulation, peak tracking and block counter.
// Emits single-cycle done/over strobes on the sample that completes a block.
module dsp_power_acc
   import dsp_subsystem_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             en,
   input  logic             clr,
   input  logic             tvalid,
   input  logic [31:0]      tdata,
   input  logic [15:0]      blk_len,
   input  logic [31:0]      thresh,
   output blk_result_t      result,
   output logic [CNT_W-1:0] cnt,
   output logic [31:0]      last_iq,
   output logic             blk_done,
   output logic             blk_over
);

   localparam int PW = 2 * DW;

   logic signed [DW-1:0] i_s;
   logic signed [DW-1:0] q_s;
   logic signed [PW-1:0] i_x;
   logic signed [PW-1:0] q_x;
   logic signed [PW-1:0] i_sq;
   logic signed [PW-1:0] q_sq;
   logic [31:0]          p;

   logic [ACC_W-1:0] pow_acc;
   logic [31:0]      peak;
   logic [ACC_W-1:0] acc_next;
   logic [31:0]      peak_next;
   logic             fire;

   assign i_s = tdata[DW-1:0];
   assign q_s = tdata[16+DW-1:16];

   // Operands are widened before multiplying so the signed square is exact
   assign i_x  = {{DW{i_s[DW-1]}}, i_s};
   assign q_x  = {{DW{q_s[DW-1]}}, q_s};
   assign i_sq = i_x * i_x;
   assign q_sq = q_x * q_x;
   assign p    = 32'($unsigned(i_sq)) + 32'($unsigned(q_sq));

   assign fire      = ce & tvalid & en;
   assign acc_next  = pow_acc + ACC_W'(p);
   assign peak_next = (p > peak) ? p : peak;

   // cnt+1 >= N  <=>  cnt >= BLK_LEN, which also covers a shrunk BLK_LEN
   assign blk_done = fire & ~clr & (cnt >= {1'b0, blk_len});
   assign blk_over = blk_done & (peak_next > thresh);

   // NOTE: state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pow_acc <= '0;
         peak    <= '0;
         cnt     <= '0;
         last_iq <= '0;
         result  <= '0;
      end else if (clr) begin
         pow_acc <= '0;
         peak    <= '0;
         cnt     <= '0;
      end else if (fire) begin
         last_iq <= tdata;
         if (blk_done) begin
            result.pow  <= acc_next;
            result.peak <= peak_next;
            pow_acc     <= '0;
            peak        <= '0;
            cnt         <= '0;
         end else begin
            pow_acc <= acc_next;
            peak    <= peak_next;
            cnt     <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dsp_subsystem.sv
// I/Q stream power monitor: AXI-Stream sample input, zero-wait AHB-Lite
// register file, level interrupt on block completion / threshold exceed.
module dsp_subsystem
   import dsp_subsystem_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        ce,
   input  logic [31:0] tdata_s,
   input  logic        tvalid_s,
   output logic        tready_s,
   input  logic [31:0] haddr_s,
   input  logic [2:0]  hburst_s,
   input  logic [2:0]  hsize_s,
   input  logic [1:0]  htrans_s,
   input  logic [31:0] hwdata_s,
   input  logic        hwrite_s,
   input  logic        hsel_s,
   output logic [31:0] hrdata_s,
   output logic        hreadyout_s,
   output logic        hresp_s,
   output logic        interrupts
);

   ahb_dp_t          dp;
   logic             addr_phase;
   logic             reg_wr;
   logic             clr_pulse;
   logic [1:0]       irq_w1c;
   logic [1:0]       irq_set;

   logic             ctrl_en;
   logic [15:0]      blk_len;
   logic [31:0]      thresh;
   logic [1:0]       irq_en;
   logic [1:0]       irq_stat;

   blk_result_t      result;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      last_iq;
   logic             blk_done;
   logic             blk_over;
   logic [31:0]      rdata;

   // Burst/size are irrelevant for fixed 32-bit registers
   logic unused_ahb;
   assign unused_ahb = ^{hburst_s, hsize_s, haddr_s[31:8], haddr_s[1:0], htrans_s[0]};

   assign hreadyout_s = 1'b1;
   assign hresp_s     = 1'b0;
   assign tready_s    = ce & hresetn;
   assign interrupts  = |(irq_stat & irq_en);

   assign addr_phase = hsel_s & htrans_s[1] & hreadyout_s;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dp <= '0;
      end else begin
         dp.valid <= addr_phase;
         dp.write <= hwrite_s;
         dp.idx   <= haddr_s[7:2];
      end
   end

   assign reg_wr    = dp.valid & dp.write;
   assign clr_pulse = reg_wr & (dp.idx == REG_CTRL) & hwdata_s[1];
   assign irq_w1c   = (reg_wr && dp.idx == REG_IRQ_STAT) ? hwdata_s[1:0] : 2'b00;
   assign irq_set   = {blk_over, blk_done};

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         ctrl_en  <= CTRL_EN_RST;
         blk_len  <= BLK_LEN_RST;
         thresh   <= THRESH_RST;
         irq_en   <= IRQ_EN_RST;
         irq_stat <= '0;
      end else begin
         if (reg_wr) begin
            case (dp.idx)
               REG_CTRL:    ctrl_en <= hwdata_s[0];
               REG_BLK_LEN: blk_len <= hwdata_s[15:0];
               REG_THRESH:  thresh  <= hwdata_s;
               REG_IRQ_EN:  irq_en  <= hwdata_s[1:0];
               default:     ;
            endcase
         end
         // A hardware set in the same cycle as a W1C leaves the bit set
         irq_stat <= (irq_stat & ~irq_w1c) | irq_set;
      end
   end

   // NOTE: rdata gets a default before the case so no latch is inferred.
   always_comb begin
      rdata = '0;
      if (dp.valid && !dp.write) begin
         case (dp.idx)
            REG_CTRL:       rdata = {31'b0, ctrl_en};
            REG_BLK_LEN:    rdata = {16'b0, blk_len};
            REG_THRESH:     rdata = thresh;
            REG_IRQ_EN:     rdata = {30'b0, irq_en};
            REG_IRQ_STAT:   rdata = {30'b0, irq_stat};
            REG_RES_POW_LO: rdata = result.pow[31:0];
            REG_RES_POW_HI: rdata = 32'(result.pow[ACC_W-1:32]);
            REG_RES_PEAK:   rdata = result.peak;
            REG_CNT:        rdata = 32'(cnt);
            REG_LAST_IQ:    rdata = last_iq;
            REG_ID:         rdata = ID_VALUE;
            default:        rdata = '0;
         endcase
      end
   end

   assign hrdata_s = rdata;

   dsp_power_acc #(
      .DW (DW)
   ) u_power_acc (
      .clk      (hclk),
      .rst_n    (hresetn),
      .ce       (ce),
      .en       (ctrl_en),
      .clr      (clr_pulse),
      .tvalid   (tvalid_s),
      .tdata    (tdata_s),
      .blk_len  (blk_len),
      .thresh   (thresh),
      .result   (result),
      .cnt      (cnt),
      .last_iq  (last_iq),
      .blk_done (blk_done),
      .blk_over (blk_over)
   );

endmodule

// File: tb/tb_dsp_subsystem.sv
// Scoreboard bench for dsp_subsystem: reads queue their expected data,
// a monitor compares hrdata_s in each read data phase.
module tb_dsp_subsystem;

   localparam logic [7:0] A_CTRL    = 8'h00;
   localparam logic [7:0] A_BLK_LEN = 8'h04;
   localparam logic [7:0] A_THRESH  = 8'h08;
   localparam logic [7:0] A_IRQ_EN  = 8'h0C;
   localparam logic [7:0] A_IRQ_ST  = 8'h10;
   localparam logic [7:0] A_POW_LO  = 8'h14;
   localparam logic [7:0] A_POW_HI  = 8'h18;
   localparam logic [7:0] A_PEAK    = 8'h1C;
   localparam logic [7:0] A_CNT     = 8'h20;
   localparam logic [7:0] A_LAST_IQ = 8'h24;
   localparam logic [7:0] A_ID      = 8'h28;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        ce;
   logic [31:0] tdata_s;
   logic        tvalid_s;
   logic        tready_s;
   logic [31:0] haddr_s;
   logic [2:0]  hburst_s;
   logic [2:0]  hsize_s;
   logic [1:0]  htrans_s;
   logic [31:0] hwdata_s;
   logic        hwrite_s;
   logic        hsel_s;
   logic [31:0] hrdata_s;
   logic        hreadyout_s;
   logic        hresp_s;
   logic        interrupts;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   always #5 hclk = ~hclk;

   dsp_subsystem #(.DW(16)) dut (
      .hclk        (hclk),
      .hresetn     (hresetn),
      .ce          (ce),
      .tdata_s     (tdata_s),
      .tvalid_s    (tvalid_s),
      .tready_s    (tready_s),
      .haddr_s     (haddr_s),
      .hburst_s    (hburst_s),
      .hsize_s     (hsize_s),
      .htrans_s    (htrans_s),
      .hwdata_s    (hwdata_s),
      .hwrite_s    (hwrite_s),
      .hsel_s      (hsel_s),
      .hrdata_s    (hrdata_s),
      .hreadyout_s (hreadyout_s),
      .hresp_s     (hresp_s),
      .interrupts  (interrupts)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Monitor: a read address phase seen at an edge means data is due before the next edge
   initial begin : monitor
      bit       rd;
      sb_item_t it;
      forever begin
         @(posedge hclk);
         rd = hresetn && hsel_s && htrans_s[1] && !hwrite_s;
         if (rd) begin
            @(negedge hclk);
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_read: got 0x%08h, expected no read pending", hrdata_s);
            end else begin
               it = sb_q.pop_front();
               check(it.name, hrdata_s, it.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   task automatic ahb_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
      @(posedge hclk); #1;
      hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b0; haddr_s = {24'h0, addr};
      sb_q.push_back('{name: name, exp: exp});
      @(posedge hclk); #1;
      hsel_s = 1'b0; htrans_s = 2'b00;
   endtask

   // Write; optionally presents a stream sample in the data-phase cycle
   task automatic ahb_write_s(input logic [7:0] addr, input logic [31:0] data,
                              input bit smp, input logic [15:0] i, input logic [15:0] q);
      @(posedge hclk); #1;
      hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = {24'h0, addr};
      @(posedge hclk); #1;
      hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = data;
      if (smp) begin
         tvalid_s = 1'b1; tdata_s = {q, i};
      end
      @(posedge hclk); #1;
      tvalid_s = 1'b0;
   endtask

   task automatic ahb_write(input logic [7:0] addr, input logic [31:0] data);
      ahb_write_s(addr, data, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic send(input logic [15:0] i, input logic [15:0] q);
      @(posedge hclk); #1;
      tvalid_s = 1'b1; tdata_s = {q, i};
      @(posedge hclk); #1;
      tvalid_s = 1'b0;
   endtask

   initial begin : stim
      hresetn = 1'b0; ce = 1'b1; tdata_s = '0; tvalid_s = 1'b0;
      haddr_s = '0; hburst_s = 3'b000; hsize_s = 3'b010; htrans_s = 2'b00;
      hwdata_s = '0; hwrite_s = 1'b0; hsel_s = 1'b0;

      // Outputs while held in reset
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      check("rst tready", {31'b0, tready_s}, 32'd0);
      check("rst hrdata", hrdata_s, 32'd0);
      check("rst hreadyout", {31'b0, hreadyout_s}, 32'd1);
      check("rst hresp", {31'b0, hresp_s}, 32'd0);
      check("rst interrupts", {31'b0, interrupts}, 32'd0);
      @(posedge hclk); #1 hresetn = 1'b1;
      @(negedge hclk);
      check("tready follows ce", {31'b0, tready_s}, 32'd1);

      // Reset values and unmapped reads
      ahb_read(A_CTRL,    32'h0,         "rst CTRL");
      ahb_read(A_BLK_LEN, 32'h0000_03FF, "rst BLK_LEN");
      ahb_read(A_THRESH,  32'hFFFF_FFFF, "rst THRESH");
      ahb_read(A_IRQ_EN,  32'h0,         "rst IRQ_EN");
      ahb_read(A_IRQ_ST,  32'h0,         "rst IRQ_STAT");
      ahb_read(A_POW_LO,  32'h0,         "rst RES_POW_LO");
      ahb_read(A_CNT,     32'h0,         "rst CNT");
      ahb_read(A_ID,      32'h4453_5031, "ID");
      ahb_read(8'h2C,     32'h0,         "unmapped 0x2C");
      ahb_read(8'hFC,     32'h0,         "unmapped 0xFC");

      // Four-sample block of I=Q=1
      ahb_write(A_BLK_LEN, 32'd3);
      ahb_write(A_CTRL, 32'd1);
      repeat (3) send(16'd1, 16'd1);
      ahb_read(A_CNT, 32'd3, "CNT mid block");
      send(16'd1, 16'd1);
      ahb_read(A_POW_LO,  32'd8,         "blk1 RES_POW_LO");
      ahb_read(A_POW_HI,  32'd0,         "blk1 RES_POW_HI");
      ahb_read(A_PEAK,    32'd2,         "blk1 RES_PEAK");
      ahb_read(A_IRQ_ST,  32'h1,         "blk1 IRQ_STAT");
      ahb_read(A_CNT,     32'd0,         "blk1 CNT restart");
      ahb_read(A_LAST_IQ, 32'h0001_0001, "blk1 LAST_IQ");
      ahb_write(A_PEAK, 32'h1234);
      ahb_read(A_PEAK, 32'd2, "RO write ignored");
      ahb_write(A_IRQ_ST, 32'h1);
      ahb_read(A_IRQ_ST, 32'h0, "W1C clears");

      // Full-scale sample, single-sample block
      ahb_write(A_BLK_LEN, 32'd0);
      send(16'h8000, 16'h8000);
      ahb_read(A_POW_LO, 32'h8000_0000, "max RES_POW_LO");
      ahb_read(A_POW_HI, 32'h0,         "max RES_POW_HI");
      ahb_read(A_PEAK,   32'h8000_0000, "max RES_PEAK");
      ahb_read(A_IRQ_ST, 32'h1,         "max IRQ_STAT no over");
      // Three full-scale samples carry into the upper accumulator word
      ahb_write(A_BLK_LEN, 32'd2);
      repeat (3) send(16'h8000, 16'h8000);
      ahb_read(A_POW_LO, 32'h8000_0000, "3max RES_POW_LO");
      ahb_read(A_POW_HI, 32'h1,         "3max RES_POW_HI");
      ahb_write(A_IRQ_ST, 32'h1);

      // Threshold interrupt
      ahb_write(A_THRESH, 32'd100);
      ahb_write(A_IRQ_EN, 32'h3);
      ahb_write(A_BLK_LEN, 32'd0);
      send(16'd10, 16'd1);
      ahb_read(A_IRQ_ST, 32'h3, "over IRQ_STAT");
      @(negedge hclk);
      check("over interrupts", {31'b0, interrupts}, 32'd1);
      ahb_write(A_IRQ_ST, 32'h3);
      @(negedge hclk);
      check("W1C interrupts low", {31'b0, interrupts}, 32'd0);
      send(16'd10, 16'd0);
      ahb_read(A_IRQ_ST, 32'h1, "peak == THRESH not over");
      ahb_write(A_IRQ_EN, 32'h2);
      @(negedge hclk);
      check("masked interrupts", {31'b0, interrupts}, 32'd0);
      ahb_write(A_IRQ_ST, 32'h1);
      ahb_write(A_IRQ_EN, 32'h0);

      // ce stall mid-block with tvalid held high
      ahb_write(A_BLK_LEN, 32'd9);
      repeat (2) send(16'd3, 16'd4);
      ahb_read(A_CNT, 32'd2, "CNT before stall");
      @(posedge hclk); #1;
      ce = 1'b0; tvalid_s = 1'b1; tdata_s = {16'd5, 16'd5};
      @(negedge hclk);
      check("stall tready", {31'b0, tready_s}, 32'd0);
      ahb_read(A_ID,  32'h4453_5031, "ID during stall");
      ahb_read(A_CNT, 32'd2,         "CNT during stall");
      repeat (15) @(posedge hclk);
      #1 tvalid_s = 1'b0; ce = 1'b1;
      ahb_read(A_CNT, 32'd2, "CNT after stall");

      // EN=0 discards samples
      ahb_write(A_CTRL, 32'd0);
      send(16'd7, 16'd7);
      ahb_read(A_CNT,     32'd2,         "EN=0 CNT held");
      ahb_read(A_LAST_IQ, 32'h0004_0003, "EN=0 LAST_IQ held");
      ahb_write(A_CTRL, 32'd1);
      send(16'd0, 16'd5);
      ahb_read(A_CNT,     32'd3,         "EN=1 resumes CNT");
      ahb_read(A_LAST_IQ, 32'h0005_0000, "EN=1 LAST_IQ");

      // CLR coincident with an accepted sample
      ahb_write_s(A_CTRL, 32'd3, 1'b1, 16'd1, 16'd1);
      ahb_read(A_CNT,  32'd0, "CLR wins CNT");
      ahb_read(A_CTRL, 32'd1, "CLR reads 0");
      ahb_write(A_BLK_LEN, 32'd1);
      repeat (2) send(16'd1, 16'd0);
      ahb_read(A_POW_LO, 32'd2, "post-CLR RES_POW_LO");
      ahb_read(A_PEAK,   32'd1, "post-CLR RES_PEAK");
      ahb_read(A_IRQ_ST, 32'h1, "post-CLR IRQ_STAT");

      // Hardware set coincident with W1C of the same bit
      send(16'd1, 16'd0);
      ahb_write_s(A_IRQ_ST, 32'h1, 1'b1, 16'd2, 16'd0);
      ahb_read(A_IRQ_ST, 32'h1, "set beats W1C");
      ahb_read(A_POW_LO, 32'd5, "set/W1C RES_POW_LO");
      ahb_write(A_IRQ_ST, 32'h1);
      ahb_read(A_IRQ_ST, 32'h0, "W1C after set");

      // BLK_LEN shrunk below current CNT
      ahb_write(A_BLK_LEN, 32'd9);
      repeat (3) send(16'd1, 16'd0);
      ahb_read(A_CNT, 32'd3, "CNT before shrink");
      ahb_write(A_BLK_LEN, 32'd1);
      send(16'd2, 16'd0);
      ahb_read(A_POW_LO, 32'd7, "shrink RES_POW_LO");
      ahb_read(A_PEAK,   32'd4, "shrink RES_PEAK");
      ahb_read(A_CNT,    32'd0, "shrink CNT");
      ahb_write(A_IRQ_ST, 32'h1);

      // Reset mid-block
      ahb_write(A_IRQ_EN, 32'h1);
      ahb_write(A_BLK_LEN, 32'd3);
      repeat (2) send(16'd1, 16'd1);
      @(posedge hclk); #1 hresetn = 1'b0;
      @(negedge hclk);
      check("mid rst interrupts", {31'b0, interrupts}, 32'd0);
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;
      ahb_read(A_CNT,     32'd0,         "post rst CNT");
      ahb_read(A_IRQ_ST,  32'h0,         "post rst IRQ_STAT");
      ahb_read(A_BLK_LEN, 32'h0000_03FF, "post rst BLK_LEN");
      ahb_read(A_POW_LO,  32'h0,         "post rst RES_POW_LO");
      ahb_read(A_IRQ_EN,  32'h0,         "post rst IRQ_EN");
      @(negedge hclk);
      check("post rst interrupts", {31'b0, interrupts}, 32'd0);

      // Drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge hclk);
      repeat (2) @(posedge hclk);
      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", sb_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
